// File: rtl/fpga_iser8_align_pkg.sv
// fpga_iser8_align_pkg: shared state type, default constants and offset priority helper for the word aligner
package fpga_iser8_align_pkg;
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_t;
  localparam logic [7:0] ALIGN_SYNC_WORD = 8'hD5;
  localparam int         ALIGN_LOCK_CNT  = 4;
  // Index of the lowest set bit; 0 when none is set.
  function automatic logic [2:0] first_set8(input logic [7:0] v);
    first_set8 = 3'd0;
    for (int i = 7; i >= 0; i--) if (v[i]) first_set8 = 3'(i);
  endfunction
endpackage

// File: rtl/fpga_bitsel8.sv
// fpga_bitsel8: combinational 16-to-8 selector returning w[sel+7:sel]
// w: two-word window (lower byte older), sel: bit offset, y: selected byte
module fpga_bitsel8 (
  input  logic [15:0] w,
  input  logic [2:0]  sel,
  output logic [7:0]  y
);
  assign y = 8'(w >> sel);
endmodule

// File: rtl/fpga_iser8_align.sv
// fpga_iser8_align: hunts for SYNC_WORD at every bit offset of an 8:1 deserialized lane, locks, and emits aligned bytes
// clk_par/arst_n: parallel clock and async active-low reset; q: raw word (bit 0 earliest)
// realign: pulse forcing HUNT; dout/dout_vld: aligned byte and its valid; locked/offset: lock status and bit offset
module fpga_iser8_align
  import fpga_iser8_align_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD = ALIGN_SYNC_WORD,
  parameter int         LOCK_CNT  = ALIGN_LOCK_CNT
) (
  input  logic       clk_par,
  input  logic       arst_n,
  input  logic [7:0] q,
  input  logic       realign,
  output logic [7:0] dout,
  output logic       dout_vld,
  output logic       locked,
  output logic [2:0] offset
);
  align_state_t state_q, state_d;
  logic [7:0]  q_r_q, q_p_q;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic [2:0]  offset_q, offset_d;
  logic [7:0]  dout_q, dout_d, dout_sel;
  logic [15:0] w;
  logic [7:0]  m;
  logic        final_hit;
  assign w = {q_r_q, q_p_q};
  for (genvar k = 0; k < 8; k++) begin : g_m
    logic [7:0] c;
    fpga_bitsel8 u_sel (.w(w), .sel(3'(k)), .y(c));
    assign m[k] = c == SYNC_WORD;
  end
  // Selecting with offset_d lets the byte that completes lock be delivered on the lock edge.
  fpga_bitsel8 u_dout (.w(w), .sel(offset_d), .y(dout_sel));
  assign cnt_inc   = &cnt_q ? cnt_q : cnt_q + 8'd1;
  assign final_hit = {1'b0, cnt_q} + 9'd1 >= 9'(LOCK_CNT);
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    offset_d = offset_q;
    if (realign) begin
      state_d = HUNT;
      cnt_d   = 8'd0;
    end else begin
      case (state_q)
        HUNT: if (|m) begin
          offset_d = first_set8(m);
          cnt_d    = 8'd1;
          state_d  = (LOCK_CNT == 1) ? LOCKED : VERIFY;
        end
        VERIFY: if (m[offset_q]) begin
          cnt_d   = cnt_inc;
          state_d = final_hit ? LOCKED : VERIFY;
        end else begin
          cnt_d   = 8'd0;
          state_d = HUNT;
        end
        default: ;
      endcase
    end
  end
  assign dout_d = (state_d == LOCKED) ? dout_sel : dout_q;
  always_ff @(posedge clk_par or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= HUNT;
      q_r_q    <= 8'h00;
      q_p_q    <= 8'h00;
      cnt_q    <= 8'd0;
      offset_q <= 3'd0;
      dout_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      q_r_q    <= q;
      q_p_q    <= q_r_q;
      cnt_q    <= cnt_d;
      offset_q <= offset_d;
      dout_q   <= dout_d;
    end
  end
  assign dout     = dout_q;
  assign dout_vld = state_q == LOCKED;
  assign locked   = state_q == LOCKED;
  assign offset   = offset_q;
endmodule
